// File: rtl/trips_opnet_pkg.sv
// Shared types for the E-grid operand network: port numbering, operand slots,
// the default flit layout and the round-robin pick helper used by every output.
package trips_opnet_pkg;

  localparam int NP          = 5;
  localparam int COORD_W     = 4;
  localparam int DEF_DATA_W  = 64;
  localparam int DEF_INSTR_W = 7;

  typedef enum logic [2:0] {
    P_N = 3'd0,
    P_S = 3'd1,
    P_E = 3'd2,
    P_W = 3'd3,
    P_L = 3'd4
  } port_t;

  typedef enum logic [1:0] {
    SLOT_LEFT  = 2'd0,
    SLOT_RIGHT = 2'd1,
    SLOT_PRED  = 2'd2
  } slot_t;

  // Field order (MSB first) is the wire format; routers slice it with their own widths.
  typedef struct packed {
    logic                   valid;
    logic [COORD_W-1:0]     dest_row;
    logic [COORD_W-1:0]     dest_col;
    logic [DEF_INSTR_W-1:0] dest_instr;
    logic [1:0]             dest_slot;
    logic [DEF_DATA_W-1:0]  data;
  } operand_flit_t;

  // Returns {found, index}: first set bit of req scanning upward from ptr, wrapping.
  function automatic logic [3:0] rr_pick(input logic [NP-1:0] req, input logic [2:0] ptr);
    logic [3:0] res;
    logic [3:0] idx;
    res = '0;
    for (int k = NP - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 4'(k);
      if (idx >= 4'(NP)) idx = idx - 4'(NP);
      if (req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/opnet_fifo.sv
// Count-based input FIFO with a registered head: a pushed entry becomes visible
// at the head one edge after it is written, and full/empty are registered flags.
module opnet_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr, rd_ptr_next;
  logic [AW:0]      count, count_left, count_next;
  logic             push_ok, pop_ok;

  always_comb begin
    push_ok     = push & ~full;
    pop_ok      = pop & ~empty;
    rd_ptr_next = rd_ptr + AW'(pop_ok);
    count_left  = count - (AW + 1)'(pop_ok);
    count_next  = count_left + (AW + 1)'(push_ok);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // empty tracks only entries written before this edge, so the registered read is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      rdata  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_ok);
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      full   <= (count_next == DEPTH_C);
      empty  <= (count_left == '0);
      rdata  <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/operand_mesh_router.sv
// One 5-port XY mesh router node: per-input FIFOs, two-class round-robin
// arbitration per output, a registered output stage and off-grid drop accounting.
module operand_mesh_router
  import trips_opnet_pkg::*;
#(
  parameter int GRID_ROWS = 4,
  parameter int GRID_COLS = 4,
  parameter int ROW_ID    = 0,
  parameter int COL_ID    = 0,
  parameter int DATA_W    = 64,
  parameter int INSTR_W   = 7,
  parameter int BUF_DEPTH = 4,
  localparam int FLIT_W   = 1 + 2 * COORD_W + INSTR_W + 2 + DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NP-1:0]              in_valid,
  input  logic [NP-1:0][FLIT_W-1:0]  in_flit,
  output logic [NP-1:0]              in_ready,
  output logic [NP-1:0]              out_valid,
  output logic [NP-1:0][FLIT_W-1:0]  out_flit,
  input  logic [NP-1:0]              out_ready,
  output logic                       err_drop,
  output logic [15:0]                drop_count
);

  localparam int SLOT_LSB = DATA_W;
  localparam int COL_LSB  = DATA_W + 2 + INSTR_W;
  localparam int ROW_LSB  = COL_LSB + COORD_W;
  localparam logic [COORD_W-1:0] MY_ROW = COORD_W'(ROW_ID);
  localparam logic [COORD_W-1:0] MY_COL = COORD_W'(COL_ID);
  localparam logic [COORD_W:0]   ROWS_LIM = (COORD_W + 1)'(GRID_ROWS);
  localparam logic [COORD_W:0]   COLS_LIM = (COORD_W + 1)'(GRID_COLS);

  logic [FLIT_W-1:0]       head [NP];
  logic [NP-1:0]           head_empty, fifo_full, pop, drop, hi;
  logic [NP-1:0][NP-1:0]   req;   // [output][input]
  logic [NP-1:0][NP-1:0]   gnt;   // [output][input]
  logic [2:0]              n_drop;
  logic [16:0]             drop_sum;

  generate
    for (genvar gi = 0; gi < NP; gi++) begin : g_in
      logic [COORD_W-1:0] row, col;
      logic               off_grid, routable;
      port_t              rt;

      opnet_fifo #(.DEPTH(BUF_DEPTH), .WIDTH(FLIT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid[gi]),
        .wdata (in_flit[gi]),
        .pop   (pop[gi]),
        .rdata (head[gi]),
        .full  (fifo_full[gi]),
        .empty (head_empty[gi])
      );

      assign in_ready[gi] = ~fifo_full[gi];
      assign row = head[gi][ROW_LSB +: COORD_W];
      assign col = head[gi][COL_LSB +: COORD_W];

      always_comb begin
        rt = P_L;
        if (col > MY_COL)      rt = P_E;
        else if (col < MY_COL) rt = P_W;
        else if (row > MY_ROW) rt = P_S;
        else if (row < MY_ROW) rt = P_N;
      end

      assign off_grid = ({1'b0, row} >= ROWS_LIM) || ({1'b0, col} >= COLS_LIM);
      assign drop[gi] = ~head_empty[gi] & off_grid;
      // A head that would turn back to its own input port is never offered.
      assign routable = ~head_empty[gi] & ~off_grid & (rt != port_t'(gi));
      assign hi[gi]   = (head[gi][SLOT_LSB +: 2] == SLOT_PRED);

      for (genvar gj = 0; gj < NP; gj++) begin : g_req
        assign req[gj][gi] = routable & (rt == port_t'(gj));
      end
    end

    for (genvar gj = 0; gj < NP; gj++) begin : g_out
      logic [NP-1:0]     hi_req, lo_req;
      logic [3:0]        pick;
      logic              grant_en;
      logic [2:0]        ptr_reg;
      logic              valid_reg;
      logic [FLIT_W-1:0] flit_reg;

      assign hi_req   = req[gj] & hi;
      assign lo_req   = req[gj] & ~hi;
      assign pick     = (|hi_req) ? rr_pick(hi_req, ptr_reg) : rr_pick(lo_req, ptr_reg);
      assign grant_en = (~valid_reg | out_ready[gj]) & pick[3];

      for (genvar gi = 0; gi < NP; gi++) begin : g_gnt
        assign gnt[gj][gi] = grant_en & (pick[2:0] == 3'(gi));
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr_reg   <= '0;
          valid_reg <= 1'b0;
          flit_reg  <= '0;
        end else if (grant_en) begin
          valid_reg <= 1'b1;
          flit_reg  <= head[pick[2:0]];
          ptr_reg   <= (pick[2:0] == 3'(NP - 1)) ? 3'd0 : pick[2:0] + 3'd1;
        end else if (out_ready[gj]) begin
          valid_reg <= 1'b0;
        end
      end

      assign out_valid[gj] = valid_reg;
      assign out_flit[gj]  = flit_reg;
    end
  endgenerate

  always_comb begin
    pop = drop;
    for (int o = 0; o < NP; o++) pop = pop | gnt[o];
    n_drop = '0;
    for (int i = 0; i < NP; i++) n_drop = n_drop + 3'(drop[i]);
    drop_sum = {1'b0, drop_count} + 17'(n_drop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop   <= 1'b0;
      drop_count <= '0;
    end else begin
      err_drop   <= |drop;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_operand_mesh_router.sv
// Scoreboard bench for router (1,1) of a 4x4 grid: directed flits push expected
// outputs per port; a negedge monitor pops and compares every delivered flit.
module tb_operand_mesh_router;
  import trips_opnet_pkg::*;

  localparam int DW = 64;
  localparam int IW = 7;
  localparam int FW = 1 + 2 * COORD_W + IW + 2 + DW;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NP-1:0]         in_valid, in_ready, out_valid, out_ready;
  logic [NP-1:0][FW-1:0] in_flit, out_flit;
  logic                  err_drop;
  logic [15:0]           drop_count;

  always #5 clk = ~clk;

  operand_mesh_router #(
    .GRID_ROWS(4), .GRID_COLS(4), .ROW_ID(1), .COL_ID(1),
    .DATA_W(DW), .INSTR_W(IW), .BUF_DEPTH(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_flit    (in_flit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_flit   (out_flit),
    .out_ready  (out_ready),
    .err_drop   (err_drop),
    .drop_count (drop_count)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0;
  logic [FW-1:0] exp_q [NP][$];
  bit          tp_on = 1'b0;
  int          tp_cnt = 0;
  int unsigned tp_first = 0, tp_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [FW-1:0] mk(int row, int col, int instr, int slot, logic [63:0] data);
    return {1'b1, 4'(row), 4'(col), 7'(instr), 2'(slot), data};
  endfunction

  task automatic check(string name, logic [FW-1:0] act, logic [FW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic int total_q();
    int s = 0;
    for (int o = 0; o < NP; o++) s += exp_q[o].size();
    return s;
  endfunction

  // Monitor: a transfer happens at the next posedge whenever valid&ready at negedge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < NP; o++) begin
        if (out_valid[o] && out_ready[o]) begin
          if (exp_q[o].size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL out[%0d] unexpected: got %h, expected no flit", o, out_flit[o]);
          end else begin
            logic [FW-1:0] e;
            e = exp_q[o].pop_front();
            check($sformatf("out[%0d] flit", o), out_flit[o], e);
            $display("out[%0d] cyc=%0d data=%h", o, cyc, out_flit[o][DW-1:0]);
          end
          if (tp_on && o == int'(P_E)) begin
            if (tp_cnt == 0) tp_first = cyc;
            tp_last = cyc;
            tp_cnt++;
          end
        end
      end
    end
  end

  task automatic accept(int p, string name, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready[p];
      @(posedge clk);
      waited++;
    end
    #1;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: in_ready[%0d] stayed 0, expected accept", name, p);
    end
  endtask

  task automatic drain(string name);
    int k = 0;
    while (total_q() > 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    n_cmp++;
    if (total_q() != 0) begin
      n_bad++;
      $display("FAIL %s drain: %0d flits outstanding, expected 0", name, total_q());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int w, remaining, guard, tp_cycles;
    logic [FW-1:0] f, first_e;
    in_valid  = '0;
    in_flit   = '0;
    out_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 5'h1F);
    check("reset drop_count", drop_count, 0);
    check("reset err_drop", err_drop, 0);
    check("reset out_flit E", out_flit[P_E], 0);
    rst_n = 1'b1;
    out_ready = '1;
    @(posedge clk);
    #1;

    // Local inject to (1,3): two-cycle hop onto E
    f = mk(1, 3, 5, 0, 64'hDEAD_BEEF_0000_0001);
    in_valid[P_L] = 1'b1;
    in_flit[P_L]  = f;
    exp_q[P_E].push_back(f);
    @(posedge clk);
    #1 in_valid[P_L] = 1'b0;
    @(posedge clk);
    @(negedge clk) check("latency t+1 out_valid E", out_valid[P_E], 0);
    @(posedge clk);
    @(negedge clk) check("latency t+2 out_valid E", out_valid[P_E], 1);
    drain("local inject");

    // N and W both to L, slot 0: expect N,W,N,W
    exp_q[P_L].push_back(mk(1, 1, 1, 0, 64'hA1));
    exp_q[P_L].push_back(mk(1, 1, 2, 0, 64'hB1));
    exp_q[P_L].push_back(mk(1, 1, 3, 0, 64'hA2));
    exp_q[P_L].push_back(mk(1, 1, 4, 0, 64'hB2));
    in_valid[P_N] = 1'b1; in_flit[P_N] = mk(1, 1, 1, 0, 64'hA1);
    in_valid[P_W] = 1'b1; in_flit[P_W] = mk(1, 1, 2, 0, 64'hB1);
    @(posedge clk);
    #1;
    in_flit[P_N] = mk(1, 1, 3, 0, 64'hA2);
    in_flit[P_W] = mk(1, 1, 4, 0, 64'hB2);
    @(posedge clk);
    #1;
    in_valid = '0;
    drain("rr contention");

    // Last L grant to N leaves ptr at S, so plain RR would favour W; the pred flit must win
    out_ready[P_L] = 1'b0;
    f = mk(1, 1, 5, 0, 64'hA3);
    exp_q[P_L].push_back(f);
    in_valid[P_N] = 1'b1; in_flit[P_N] = f;
    @(posedge clk);
    #1 in_valid[P_N] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_q[P_L].push_back(mk(1, 1, 7, 2, 64'hC3));
    exp_q[P_L].push_back(mk(1, 1, 6, 0, 64'hB3));
    in_valid[P_W] = 1'b1; in_flit[P_W] = mk(1, 1, 6, 0, 64'hB3);
    in_valid[P_N] = 1'b1; in_flit[P_N] = mk(1, 1, 7, 2, 64'hC3);
    @(posedge clk);
    #1 in_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk) check("held out_flit L", out_flit[P_L], f);
    @(posedge clk);
    #1 out_ready[P_L] = 1'b1;
    drain("pred priority");

    // Backpressure on E: 1 in output stage + 4 in FIFO, 6th waits
    out_ready[P_E] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      f = mk(1, 3, k, 1, 64'h100 + 64'(k));
      if (k == 0) first_e = f;
      exp_q[P_E].push_back(f);
      in_valid[P_L] = 1'b1;
      in_flit[P_L]  = f;
      accept(P_L, "bp accept", w);
    end
    f = mk(1, 3, 5, 1, 64'h105);
    exp_q[P_E].push_back(f);
    in_flit[P_L] = f;
    @(negedge clk) check("bp in_ready L after 5", in_ready[P_L], 0);
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("bp in_ready L held", in_ready[P_L], 0);
    check("bp out_valid E", out_valid[P_E], 1);
    check("bp out_flit E stable", out_flit[P_E], first_e);
    @(posedge clk);
    #1 out_ready[P_E] = 1'b1;
    accept(P_L, "bp 6th accept", w);
    in_valid[P_L] = 1'b0;
    drain("backpressure");

    // Single off-grid drop: (4,0)
    check("err_drop idle", err_drop, 0);
    in_valid[P_L] = 1'b1;
    in_flit[P_L]  = mk(4, 0, 0, 0, 64'hD0);
    @(posedge clk);
    #1 in_valid[P_L] = 1'b0;
    @(posedge clk);
    @(negedge clk) check("err_drop t+1", err_drop, 0);
    @(posedge clk);
    @(negedge clk);
    check("err_drop t+2 pulse", err_drop, 1);
    check("drop no out_valid", out_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("err_drop t+3 clear", err_drop, 0);
    check("drop_count one", drop_count, 1);
    @(posedge clk);
    #1;

    // Fill drop_count to 0xFFFE using all five inputs
    remaining = 65533;
    guard = 0;
    while (remaining > 0 && guard < 20000) begin
      for (int p = 0; p < NP; p++) begin
        in_valid[p] = (p < remaining);
        in_flit[p]  = mk(9, p, 0, 0, 64'(guard));
      end
      @(negedge clk);
      for (int p = 0; p < NP; p++) if (in_valid[p] && in_ready[p]) remaining--;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = '0;
    check("bulk drops issued", remaining, 0);
    repeat (5) @(posedge clk);
    @(negedge clk) check("drop_count FFFE", drop_count, 16'hFFFE);
    @(posedge clk);
    #1;
    in_valid[P_N] = 1'b1; in_flit[P_N] = mk(1, 7, 0, 0, 64'hE1);
    in_valid[P_S] = 1'b1; in_flit[P_S] = mk(6, 6, 0, 0, 64'hE2);
    @(posedge clk);
    #1 in_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk) check("drop_count saturate", drop_count, 16'hFFFF);
    @(posedge clk);
    #1;
    in_valid[P_E] = 1'b1; in_flit[P_E] = mk(4, 0, 0, 0, 64'hE3);
    @(posedge clk);
    #1 in_valid = '0;
    repeat (4) @(posedge clk);
    @(negedge clk) check("drop_count sticks", drop_count, 16'hFFFF);
    @(posedge clk);
    #1;

    // Throughput W->E, 100 back-to-back flits
    tp_on = 1'b1;
    tp_cycles = 0;
    in_valid[P_W] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      f = mk(1, 3, k, 0, 64'h5000 + 64'(k));
      exp_q[P_E].push_back(f);
      in_flit[P_W] = f;
      accept(P_W, "tp accept", w);
      tp_cycles += w;
    end
    in_valid[P_W] = 1'b0;
    drain("throughput");
    tp_on = 1'b0;
    check("tp accept cycles", tp_cycles, 100);
    check("tp output count", tp_cnt, 100);
    n_cmp++;
    if (tp_last - tp_first > 100) begin
      n_bad++;
      $display("FAIL tp span: got %0d cycles first-to-last, expected at most 100", tp_last - tp_first);
    end

    // Reset in the middle of traffic
    out_ready[P_E] = 1'b0;
    in_valid[P_L] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_flit[P_L] = mk(1, 3, k, 0, 64'h900 + 64'(k));
      @(posedge clk);
      #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 5'h1F);
    check("midrst drop_count", drop_count, 0);
    in_valid = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = '1;
    repeat (4) @(posedge clk);
    #1;
    f = mk(1, 3, 9, 1, 64'h0BAD_F00D);
    exp_q[P_E].push_back(f);
    in_valid[P_L] = 1'b1;
    in_flit[P_L]  = f;
    @(posedge clk);
    #1 in_valid[P_L] = 1'b0;
    drain("post reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
